// File: rtl/alu_uart_ctrl_if.sv
// Signal bundle between the command sequencer, the UART rx/tx pair and the ALU.
// The slave side is the sequencer; the master side drives received bytes and tx completion.
interface alu_uart_ctrl_if #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
);
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_done;
    logic               i_tx_done;
    logic [NB_DATA-1:0] i_alu_result;
    logic [NB_DATA-1:0] o_data_a;
    logic [NB_DATA-1:0] o_data_b;
    logic [NB_OP-1:0]   o_op;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_busy;
    logic               o_timeout;

    modport slave (
        input  i_rx_data, i_rx_done, i_tx_done, i_alu_result,
        output o_data_a, o_data_b, o_op, o_tx_data, o_tx_start, o_busy, o_timeout
    );

    modport master (
        output i_rx_data, i_rx_done, i_tx_done, i_alu_result,
        input  o_data_a, o_data_b, o_op, o_tx_data, o_tx_start, o_busy, o_timeout
    );
endinterface

// File: rtl/alu_uart_ctrl.sv
// Collects operand A, operand B and opcode from three UART bytes, lets the ALU settle
// for one cycle on registered inputs, then hands the result to the UART transmitter.
module alu_uart_ctrl #(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic           i_clock,
    input  logic           i_reset,
    alu_uart_ctrl_if.slave bus
);
    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_WAIT_A,
        S_WAIT_B,
        S_WAIT_OP,
        S_EXEC,
        S_WAIT_TX
    } state_t;

    state_t             state_reg,    state_next;
    logic [CNT_W-1:0]   cnt_reg,      cnt_next;
    logic [NB_DATA-1:0] data_a_reg,   data_a_next;
    logic [NB_DATA-1:0] data_b_reg,   data_b_next;
    logic [NB_OP-1:0]   op_reg,       op_next;
    logic [NB_DATA-1:0] tx_data_reg,  tx_data_next;
    logic               tx_start_reg, tx_start_next;
    logic               timeout_reg,  timeout_next;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_reg    <= S_WAIT_A;
            cnt_reg      <= '0;
            data_a_reg   <= '0;
            data_b_reg   <= '0;
            op_reg       <= '0;
            tx_data_reg  <= '0;
            tx_start_reg <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            data_a_reg   <= data_a_next;
            data_b_reg   <= data_b_next;
            op_reg       <= op_next;
            tx_data_reg  <= tx_data_next;
            tx_start_reg <= tx_start_next;
            timeout_reg  <= timeout_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        data_a_next   = data_a_reg;
        data_b_next   = data_b_reg;
        op_next       = op_reg;
        tx_data_next  = tx_data_reg;
        tx_start_next = 1'b0;
        timeout_next  = 1'b0;
        case (state_reg)
            S_WAIT_A: begin
                cnt_next = '0;
                if (bus.i_rx_done) begin
                    data_a_next = bus.i_rx_data;
                    state_next  = S_WAIT_B;
                end
            end
            S_WAIT_B: begin
                // A byte arriving in the expiry cycle still counts.
                if (bus.i_rx_done) begin
                    data_b_next = bus.i_rx_data;
                    cnt_next    = '0;
                    state_next  = S_WAIT_OP;
                end else if (cnt_reg == CNT_LAST) begin
                    cnt_next     = '0;
                    timeout_next = 1'b1;
                    state_next   = S_WAIT_A;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_WAIT_OP: begin
                if (bus.i_rx_done) begin
                    op_next    = bus.i_rx_data[NB_OP-1:0];
                    cnt_next   = '0;
                    state_next = S_EXEC;
                end else if (cnt_reg == CNT_LAST) begin
                    cnt_next     = '0;
                    timeout_next = 1'b1;
                    state_next   = S_WAIT_A;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_EXEC: begin
                tx_data_next  = bus.i_alu_result;
                tx_start_next = 1'b1;
                state_next    = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (bus.i_tx_done) begin
                    state_next = S_WAIT_A;
                end
            end
            default: state_next = S_WAIT_A;
        endcase
    end

    assign bus.o_data_a   = data_a_reg;
    assign bus.o_data_b   = data_b_reg;
    assign bus.o_op       = op_reg;
    assign bus.o_tx_data  = tx_data_reg;
    assign bus.o_tx_start = tx_start_reg;
    assign bus.o_timeout  = timeout_reg;
    assign bus.o_busy     = (state_reg == S_EXEC) || (state_reg == S_WAIT_TX);
endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Directed bench for alu_uart_ctrl: a stand-in ALU, stimulus tasks pushing expected
// tx/timeout events, and a monitor popping them whenever the DUT pulses an output.
module tb_alu_uart_ctrl;
    localparam int NB_DATA = 8;
    localparam int NB_OP   = 6;
    localparam int TO      = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_uart_ctrl_if #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) bus ();

    alu_uart_ctrl #(
        .NB_DATA(NB_DATA),
        .NB_OP(NB_OP),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .bus(bus)
    );

    // Stand-in ALU with MIPS-style function codes
    always_comb begin
        case (bus.o_op)
            6'h20:   bus.i_alu_result = bus.o_data_a + bus.o_data_b;
            6'h22:   bus.i_alu_result = bus.o_data_a - bus.o_data_b;
            6'h24:   bus.i_alu_result = bus.o_data_a & bus.o_data_b;
            6'h25:   bus.i_alu_result = bus.o_data_a | bus.o_data_b;
            default: bus.i_alu_result = '0;
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit         is_to;
        logic [7:0] val;
        int         at;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every output pulse must match the head of the expectation queue
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_tx_start) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_tx_start", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("[TB] tx_start data=0x%02h cycle=%0d", bus.o_tx_data, cyc);
                    check("tx_event_kind", {31'd0, e.is_to}, 32'd0);
                    check("tx_data", bus.o_tx_data, e.val);
                    check("tx_cycle", cyc, e.at);
                end
            end
            if (bus.o_timeout) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_timeout", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("[TB] timeout cycle=%0d", cyc);
                    check("to_event_kind", {31'd0, e.is_to}, 32'd1);
                    check("to_cycle", cyc, e.at);
                end
            end
        end
    end

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(logic [7:0] b);
        bus.i_rx_data = b;
        bus.i_rx_done = 1'b1;
        @(posedge clk);
        #1;
        bus.i_rx_done = 1'b0;
        $display("[TB] rx byte 0x%02h cycle=%0d", b, cyc);
    endtask

    task automatic send_cmd(logic [7:0] a, logic [7:0] b, logic [7:0] op, logic [7:0] res);
        send(a);
        send(b);
        send(op);
        exp_q.push_back('{is_to: 1'b0, val: res, at: cyc + 1});
    endtask

    task automatic wait_start();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.o_tx_start && n < 20);
        check("tx_start_seen", {31'd0, bus.o_tx_start}, 32'd1);
        check("busy_in_wait_tx", {31'd0, bus.o_busy}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_tx_done();
        idle(2);
        check("start_single_pulse", {31'd0, bus.o_tx_start}, 32'd0);
        bus.i_tx_done = 1'b1;
        @(posedge clk);
        #1;
        bus.i_tx_done = 1'b0;
        check("busy_after_tx_done", {31'd0, bus.o_busy}, 32'd0);
    endtask

    task automatic check_zero(string tag);
        check({tag, "_data_a"},   bus.o_data_a, 32'd0);
        check({tag, "_data_b"},   bus.o_data_b, 32'd0);
        check({tag, "_op"},       bus.o_op, 32'd0);
        check({tag, "_tx_data"},  bus.o_tx_data, 32'd0);
        check({tag, "_tx_start"}, {31'd0, bus.o_tx_start}, 32'd0);
        check({tag, "_busy"},     {31'd0, bus.o_busy}, 32'd0);
        check({tag, "_timeout"},  {31'd0, bus.o_timeout}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.i_rx_data = '0;
        bus.i_rx_done = 1'b0;
        bus.i_tx_done = 1'b0;
        idle(3);
        check_zero("reset");
        rst = 1'b0;
        idle(1);

        // ADD 1+1
        send(8'h01);
        check("add_data_a", bus.o_data_a, 32'h01);
        send(8'h01);
        check("add_data_b", bus.o_data_b, 32'h01);
        send(8'h20);
        exp_q.push_back('{is_to: 1'b0, val: 8'h02, at: cyc + 1});
        check("add_op", bus.o_op, 32'h20);
        check("busy_in_exec", {31'd0, bus.o_busy}, 32'd1);
        check("no_start_in_exec", {31'd0, bus.o_tx_start}, 32'd0);
        wait_start();
        do_tx_done();
        check("tx_data_held", bus.o_tx_data, 32'h02);

        // Back-to-back SUB then AND
        send_cmd(8'h05, 8'h07, 8'h22, 8'hFE);
        wait_start();
        do_tx_done();
        send_cmd(8'hF0, 8'h3C, 8'h24, 8'h30);
        wait_start();
        do_tx_done();

        // Inter-byte timeout
        send(8'h09);
        exp_q.push_back('{is_to: 1'b1, val: 8'h00, at: cyc + TO});
        idle(TO + 2);
        check("to_busy", {31'd0, bus.o_busy}, 32'd0);
        check("to_keeps_a", bus.o_data_a, 32'h09);
        send_cmd(8'h03, 8'h04, 8'h20, 8'h07);
        wait_start();
        do_tx_done();

        // Byte arriving in the expiry cycle wins over the timeout
        send(8'h11);
        idle(TO - 1);
        send(8'h02);
        check("race_data_b", bus.o_data_b, 32'h02);
        send(8'h20);
        exp_q.push_back('{is_to: 1'b0, val: 8'h13, at: cyc + 1});
        check("race_op", bus.o_op, 32'h20);
        wait_start();
        do_tx_done();

        // Bytes during transmit are dropped; opcode upper bits discarded
        send_cmd(8'h0F, 8'hF0, 8'h25, 8'hFF);
        wait_start();
        send(8'hAA);
        send(8'hBB);
        check("drop_data_a", bus.o_data_a, 32'h0F);
        check("drop_data_b", bus.o_data_b, 32'hF0);
        check("drop_op", bus.o_op, 32'h25);
        do_tx_done();
        send_cmd(8'h0A, 8'h05, 8'hE2, 8'h05);
        check("op_low_bits", bus.o_op, 32'h22);
        wait_start();
        do_tx_done();

        // Reset in S_WAIT_OP
        send(8'h01);
        send(8'h02);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_zero("rst_wait_op");
        rst = 1'b0;
        idle(TO + 4);

        // Reset in S_WAIT_TX
        send_cmd(8'h01, 8'h01, 8'h20, 8'h02);
        wait_start();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_zero("rst_wait_tx");
        rst = 1'b0;
        idle(5);

        // Normal operation after reset
        send_cmd(8'h06, 8'h03, 8'h22, 8'h03);
        wait_start();
        do_tx_done();

        idle(3);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
